accum_warp_looper: RTL and testbench
====================================

ACCUM_WARP_LOOPER -- requirements
Module: accum_warp_looper

Interface
REQ-001 Parameter BW, default 16: width of every offset field.
REQ-002 Parameter DIM, default 2: number of vector dimensions; index 0 is outermost, DIM-1 innermost.
REQ-003 Parameter IDBW, default 3: width of the instruction/config id range fields.
REQ-004 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous and active-high.
REQ-006 src_rdy  in  1  upstream block descriptor valid.
REQ-007 src_ack  out  1  descriptor accepted this cycle.
REQ-008 i_bofs[DIM]  in  BW each  block base offset.
REQ-009 i_aofs_beg[DIM]  in  BW each  accumulation range begin, inclusive.
REQ-010 i_aofs_end[DIM]  in  BW each  accumulation range end, exclusive.
REQ-011 i_id_beg, i_id_end  in  IDBW each  id range attached to the block.
REQ-012 dst_rdy  out  1  warp descriptor valid.
REQ-013 dst_ack  in  1  downstream takes warp descriptor.
REQ-014 o_bofs[DIM], o_aofs[DIM]  out  BW each  latched base offset; current accumulation point.
REQ-015 o_id_beg, o_id_end  out  IDBW each  latched id range.
REQ-016 o_islast  out  1  current point is the final point of the block.
REQ-017 done_dval  out  1  one-cycle pulse when a block has been fully consumed.

Function
REQ-018 A transfer SHALL occur on a port only in a cycle where rdy and ack are both high; src_ack SHALL never be high while src_rdy is low; dst_rdy SHALL stay high until dst_ack is seen.
REQ-019 The FSM SHALL have two states: IDLE and RUN.
REQ-020 In IDLE, src_ack SHALL equal src_rdy (combinational, zero-bubble acceptance); in RUN, src_ack SHALL be 0.
REQ-021 On src transfer, bofs, aofs_beg, aofs_end, id_beg, id_end SHALL be latched, and o_aofs SHALL be loaded with aofs_beg.
REQ-022 Empty block (aofs_beg[i] >= aofs_end[i], unsigned, for any i): the FSM SHALL stay in IDLE, emit no dst transfer, and pulse done_dval in the cycle after acceptance.
REQ-023 Non-empty block: the FSM SHALL go to RUN; dst_rdy SHALL rise the cycle after src transfer (latency 1).
REQ-024 In RUN, dst_rdy SHALL be 1; the module SHALL hold o_* stable while dst_ack is low.
REQ-025 On a dst transfer with o_islast=0, o_aofs SHALL advance as an odometer: dim DIM-1 increments by 1; a dim reaching aofs_end[i] SHALL reload aofs_beg[i] and carry into dim i-1.
REQ-026 o_islast SHALL be 1 iff o_aofs[i] == aofs_end[i]-1 for every i (combinational from state).
REQ-027 On a dst transfer with o_islast=1, the FSM SHALL return to IDLE and pulse done_dval in that same cycle; o_aofs SHALL hold its last value.
REQ-028 A new src descriptor SHALL be accepted no earlier than the cycle after the final dst transfer (no overlap).
REQ-029 Increment arithmetic SHALL be BW+1 bits wide internally so aofs_end = 2^BW-1 does not wrap; no compare SHALL be signed.
REQ-030 Total dst transfers per block SHALL equal the product over i of (aofs_end[i]-aofs_beg[i]).

Reset
REQ-031 While i_rst=1: FSM to IDLE; src_ack, dst_rdy, done_dval, o_islast SHALL be 0; o_bofs, o_aofs, o_id_beg, o_id_end SHALL be 0.
REQ-032 Reset asserted mid-RUN SHALL abort the block at the next edge without done_dval; no dst transfer SHALL be reported for that cycle.
REQ-033 First src acceptance SHALL be possible in the first cycle after i_rst deasserts.

Verification
REQ-034 DIM=2, beg={0,0}, end={2,3}, dst_ack held 1 -> 6 transfers o_aofs {0,0},{0,1},{0,2},{1,0},{1,1},{1,2}; o_islast only on {1,2}; done_dval once, same cycle.
REQ-035 beg={1,4}, end={1,9} -> src_ack immediate, zero dst transfers, done_dval one cycle later.
REQ-036 Random dst_ack backpressure (50%) on beg={2,5}, end={4,7} -> 4 transfers, outputs stable while stalled, order {2,5},{2,6},{3,5},{3,6}.
REQ-037 Back-to-back src_rdy with two single-point blocks -> second src_ack occurs the cycle after first block's dst transfer; two done_dval pulses.
REQ-038 BW=4, end={1,15}, beg={0,13} -> transfers {0,13},{0,14}; no wrap to 0.
REQ-039 i_rst pulsed after 2 of 6 transfers -> all outputs 0 next cycle, no done_dval; fresh block then completes normally.

Source files
------------

// File: rtl/accum_warp_looper_if.sv
// Handshake bundle for accum_warp_looper: block descriptors in on src, warp
// points out on dst, plus the block-done pulse.
interface accum_warp_looper_if #(
  parameter int BW   = 16,
  parameter int DIM  = 2,
  parameter int IDBW = 3
);
  logic            src_rdy;
  logic            src_ack;
  logic [BW-1:0]   i_bofs     [DIM];
  logic [BW-1:0]   i_aofs_beg [DIM];
  logic [BW-1:0]   i_aofs_end [DIM];
  logic [IDBW-1:0] i_id_beg;
  logic [IDBW-1:0] i_id_end;

  logic            dst_rdy;
  logic            dst_ack;
  logic [BW-1:0]   o_bofs [DIM];
  logic [BW-1:0]   o_aofs [DIM];
  logic [IDBW-1:0] o_id_beg;
  logic [IDBW-1:0] o_id_end;
  logic            o_islast;
  logic            done_dval;

  modport slave (
    input  src_rdy, i_bofs, i_aofs_beg, i_aofs_end, i_id_beg, i_id_end, dst_ack,
    output src_ack, dst_rdy, o_bofs, o_aofs, o_id_beg, o_id_end, o_islast, done_dval
  );

  modport master (
    output src_rdy, i_bofs, i_aofs_beg, i_aofs_end, i_id_beg, i_id_end, dst_ack,
    input  src_ack, dst_rdy, o_bofs, o_aofs, o_id_beg, o_id_end, o_islast, done_dval
  );
endinterface

// File: rtl/accum_warp_looper.sv
// Walks every point of a DIM-dimensional accumulation range in odometer order,
// emitting one warp descriptor per point and a done pulse per block.
module accum_warp_looper #(
  parameter int BW   = 16,
  parameter int DIM  = 2,
  parameter int IDBW = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  accum_warp_looper_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bofs_q   [DIM];
  logic [BW-1:0]   beg_q    [DIM];
  logic [BW-1:0]   end_q    [DIM];
  logic [BW-1:0]   aofs_q   [DIM];
  logic [BW-1:0]   aofs_nxt [DIM];
  logic [IDBW-1:0] id_beg_q, id_end_q;
  logic            done_q;
  logic            empty_blk, islast, src_xfer, dst_xfer, carry;
  logic [BW:0]     sum;

  // One extra bit so an end value of 2^BW-1 never wraps during compare.
  function automatic logic [BW:0] inc1(input logic [BW-1:0] v);
    return {1'b0, v} + {{BW{1'b0}}, 1'b1};
  endfunction

  always_comb begin
    empty_blk = 1'b0;
    for (int i = 0; i < DIM; i++)
      if (bus.i_aofs_beg[i] >= bus.i_aofs_end[i]) empty_blk = 1'b1;
  end

  always_comb begin
    islast = 1'b1;
    for (int i = 0; i < DIM; i++)
      if (inc1(aofs_q[i]) != {1'b0, end_q[i]}) islast = 1'b0;
  end

  // Innermost dimension counts first; a dimension hitting its end reloads and carries outward.
  always_comb begin
    aofs_nxt = aofs_q;
    carry    = 1'b1;
    sum      = '0;
    for (int i = DIM-1; i >= 0; i--) begin
      sum = carry ? inc1(aofs_q[i]) : {1'b0, aofs_q[i]};
      if (carry && (sum == {1'b0, end_q[i]})) begin
        aofs_nxt[i] = beg_q[i];
      end else begin
        aofs_nxt[i] = sum[BW-1:0];
        carry       = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= src_xfer && empty_blk;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (src_xfer && !empty_blk) state_d = RUN;
      RUN:     if (dst_xfer && islast)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.src_ack   = !i_rst && (state_q == IDLE) && bus.src_rdy;
    bus.dst_rdy   = !i_rst && (state_q == RUN);
    src_xfer      = bus.src_ack;
    dst_xfer      = bus.dst_rdy && bus.dst_ack;
    bus.done_dval = !i_rst && (done_q || (dst_xfer && islast));
    bus.o_islast  = !i_rst && islast;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DIM; i++) begin
        bofs_q[i] <= '0;
        beg_q[i]  <= '0;
        end_q[i]  <= '0;
        aofs_q[i] <= '0;
      end
      id_beg_q <= '0;
      id_end_q <= '0;
    end else if (src_xfer) begin
      bofs_q   <= bus.i_bofs;
      beg_q    <= bus.i_aofs_beg;
      end_q    <= bus.i_aofs_end;
      aofs_q   <= bus.i_aofs_beg;
      id_beg_q <= bus.i_id_beg;
      id_end_q <= bus.i_id_end;
    end else if (dst_xfer && !islast) begin
      aofs_q <= aofs_nxt;
    end
  end

  assign bus.o_bofs   = bofs_q;
  assign bus.o_aofs   = aofs_q;
  assign bus.o_id_beg = id_beg_q;
  assign bus.o_id_end = id_end_q;

endmodule

// File: tb/tb_accum_warp_looper.sv
// Scoreboard bench for accum_warp_looper (BW=4, DIM=2): directed blocks with
// hand-listed expected warp points, checked by an independent monitor.
module tb_accum_warp_looper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ack_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accum_warp_looper_if #(.BW(4), .DIM(2), .IDBW(3)) bus ();

  accum_warp_looper #(.BW(4), .DIM(2), .IDBW(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] a0, a1, b0, b1;
    logic       last;
    logic [2:0] ib, ie;
  } exp_t;

  exp_t sb[$];
  int   xfer_cnt = 0, done_cnt = 0, last_xfer_cyc = -1, last_done_cyc = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] a0, a1, input logic last,
                      input logic [3:0] b0, b1, input logic [2:0] ib, ie);
    exp_t e;
    e.a0 = a0; e.a1 = a1; e.last = last; e.b0 = b0; e.b1 = b1; e.ib = ib; e.ie = ie;
    sb.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic       stall_v;
    logic [3:0] p0, p1;
    logic       pl;
    exp_t       e;
    stall_v = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.src_ack) chk("src_ack_without_rdy", bus.src_rdy, 1);
      if (stall_v && bus.dst_rdy) begin
        chk("stall_aofs0", bus.o_aofs[0], p0);
        chk("stall_aofs1", bus.o_aofs[1], p1);
        chk("stall_islast", bus.o_islast, pl);
      end
      stall_v = bus.dst_rdy && !bus.dst_ack;
      p0 = bus.o_aofs[0]; p1 = bus.o_aofs[1]; pl = bus.o_islast;
      if (bus.dst_rdy && bus.dst_ack) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("xfer_aofs0", bus.o_aofs[0], e.a0);
          chk("xfer_aofs1", bus.o_aofs[1], e.a1);
          chk("xfer_islast", bus.o_islast, e.last);
          chk("xfer_bofs0", bus.o_bofs[0], e.b0);
          chk("xfer_bofs1", bus.o_bofs[1], e.b1);
          chk("xfer_id_beg", bus.o_id_beg, e.ib);
          chk("xfer_id_end", bus.o_id_end, e.ie);
          chk("xfer_done", bus.done_dval, e.last);
        end
      end
      if (bus.done_dval) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  initial begin
    bus.dst_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       bus.dst_ack = 1'b0;
        1:       bus.dst_ack = 1'b1;
        default: bus.dst_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Present a descriptor and hold it until accepted; src_rdy stays high on return.
  task automatic send(input logic [3:0] b0, b1, g0, g1, e0, e1,
                      input logic [2:0] ib, ie, output int acc, output int waits);
    bus.i_bofs[0] = b0;     bus.i_bofs[1] = b1;
    bus.i_aofs_beg[0] = g0; bus.i_aofs_beg[1] = g1;
    bus.i_aofs_end[0] = e0; bus.i_aofs_end[1] = e1;
    bus.i_id_beg = ib;      bus.i_id_end = ie;
    bus.src_rdy = 1'b1;
    waits = 0;
    acc = -1;
    forever begin
      @(negedge clk);
      if (bus.src_ack) begin
        acc = cyc;
        break;
      end
      waits++;
      if (waits > 50) begin
        chk("src_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.dst_rdy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (n < 300), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, acc2, w, w2, d0, x0;
    bus.src_rdy = 1'b0;
    bus.i_id_beg = '0; bus.i_id_end = '0;
    for (int i = 0; i < 2; i++) begin
      bus.i_bofs[i] = '0; bus.i_aofs_beg[i] = '0; bus.i_aofs_end[i] = '0;
    end

    // Reset state, with src_rdy already high to prove src_ack is gated.
    repeat (2) @(posedge clk);
    #1 bus.src_rdy = 1'b1;
    @(negedge clk);
    chk("rst_src_ack", bus.src_ack, 0);
    chk("rst_dst_rdy", bus.dst_rdy, 0);
    chk("rst_done", bus.done_dval, 0);
    chk("rst_islast", bus.o_islast, 0);
    chk("rst_aofs0", bus.o_aofs[0], 0);
    chk("rst_aofs1", bus.o_aofs[1], 0);
    chk("rst_bofs0", bus.o_bofs[0], 0);
    chk("rst_id_end", bus.o_id_end, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 2x3 walk with dst_ack held high.
    ack_mode = 1;
    d0 = done_cnt;
    push(0, 0, 0, 3, 7, 1, 5); push(0, 1, 0, 3, 7, 1, 5); push(0, 2, 0, 3, 7, 1, 5);
    push(1, 0, 0, 3, 7, 1, 5); push(1, 1, 0, 3, 7, 1, 5); push(1, 2, 1, 3, 7, 1, 5);
    send(3, 7, 0, 0, 2, 3, 1, 5, acc, w);
    bus.src_rdy = 1'b0;
    chk("first_accept_after_rst", w, 0);
    drain();
    chk("walk_done_count", done_cnt - d0, 1);
    chk("walk_done_with_last", last_done_cyc, last_xfer_cyc);

    // Empty block: immediate accept, no transfers, done one cycle later.
    d0 = done_cnt; x0 = xfer_cnt;
    send(6, 6, 1, 4, 1, 9, 2, 3, acc, w);
    bus.src_rdy = 1'b0;
    repeat (4) @(negedge clk);
    chk("empty_accept_wait", w, 0);
    chk("empty_no_xfer", xfer_cnt - x0, 0);
    chk("empty_done_count", done_cnt - d0, 1);
    chk("empty_done_cycle", last_done_cyc, acc + 1);
    @(posedge clk);
    #1;

    // Random backpressure.
    ack_mode = 2;
    d0 = done_cnt;
    push(2, 5, 0, 8, 9, 0, 7); push(2, 6, 0, 8, 9, 0, 7);
    push(3, 5, 0, 8, 9, 0, 7); push(3, 6, 1, 8, 9, 0, 7);
    send(8, 9, 2, 5, 4, 7, 0, 7, acc, w);
    bus.src_rdy = 1'b0;
    drain();
    chk("bp_done_count", done_cnt - d0, 1);

    // Back-to-back single-point blocks.
    ack_mode = 1;
    d0 = done_cnt;
    push(0, 0, 1, 1, 2, 0, 1);
    push(5, 2, 1, 4, 5, 2, 3);
    send(1, 2, 0, 0, 1, 1, 0, 1, acc, w);
    send(4, 5, 5, 2, 6, 3, 2, 3, acc2, w2);
    bus.src_rdy = 1'b0;
    chk("b2b_second_accept_gap", acc2 - acc, 2);
    chk("b2b_second_waits", w2, 1);
    drain();
    chk("b2b_done_count", done_cnt - d0, 2);

    // Inner end at the 4-bit maximum must not wrap.
    push(0, 13, 0, 0, 0, 3, 4); push(0, 14, 1, 0, 0, 3, 4);
    send(0, 0, 0, 13, 1, 15, 3, 4, acc, w);
    bus.src_rdy = 1'b0;
    drain();

    // Reset after 2 of 6 transfers aborts without done.
    d0 = done_cnt; x0 = xfer_cnt;
    push(0, 0, 0, 9, 8, 4, 6); push(0, 1, 0, 9, 8, 4, 6);
    send(9, 8, 0, 0, 2, 3, 4, 6, acc, w);
    bus.src_rdy = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_dst_rdy", bus.dst_rdy, 0);
    chk("midrst_done", bus.done_dval, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_xfers", xfer_cnt - x0, 2);
    chk("postrst_no_done", done_cnt - d0, 0);
    chk("postrst_dst_rdy", bus.dst_rdy, 0);
    chk("postrst_islast", bus.o_islast, 0);
    chk("postrst_aofs0", bus.o_aofs[0], 0);
    chk("postrst_aofs1", bus.o_aofs[1], 0);
    chk("postrst_bofs0", bus.o_bofs[0], 0);
    chk("postrst_bofs1", bus.o_bofs[1], 0);
    chk("postrst_id_beg", bus.o_id_beg, 0);
    chk("postrst_id_end", bus.o_id_end, 0);
    @(posedge clk);
    #1;

    // Fresh block completes normally.
    d0 = done_cnt;
    push(1, 1, 0, 2, 3, 1, 2); push(1, 2, 1, 2, 3, 1, 2);
    send(2, 3, 1, 1, 2, 3, 1, 2, acc, w);
    bus.src_rdy = 1'b0;
    chk("fresh_accept_wait", w, 0);
    drain();
    chk("fresh_done_count", done_cnt - d0, 1);
    chk("sb_empty_at_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
